rsa_decrypt_core: RTL and testbench
===================================

RSA_DECRYPT_CORE -- requirements
Module: rsa_decrypt_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning an operand set is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block will accept an operand set.
REQ-006 The block SHALL have port cipher, input, WIDTH bits, the ciphertext c.
REQ-007 The block SHALL have port exp_d, input, WIDTH bits, the private exponent d.
REQ-008 The block SHALL have port mod_n, input, WIDTH bits, the modulus N.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 The block SHALL have port plain, output, WIDTH bits, the result c^d mod N.
REQ-012 The block SHALL have port err, output, 1 bit, meaning the operands were rejected; it is valid only with out_valid.

Function
REQ-013 The block SHALL accept an operand set when in_valid and in_ready are both high on a clock edge, and SHALL register cipher, exp_d and mod_n on that edge.
REQ-014 in_ready SHALL be high only in state IDLE.
REQ-015 The block SHALL use states IDLE, LOAD, SQUARE, MULT and DONE:
- IDLE->LOAD on accept.
- LOAD->DONE with err=1 and plain=0 if mod_n<2 or cipher>=mod_n.
- Otherwise LOAD->SQUARE, with acc=1 and bit index i=WIDTH-1.
REQ-016 The exponent SHALL be scanned MSB first:
- SQUARE computes acc=acc*acc mod N.
- MULT computes t=acc*c mod N.
- acc takes t only when exp_d[i]=1.
- After MULT, or after SQUARE when MULT is skipped, i decrements.
- After i=0 the block goes to DONE.
REQ-017 Each modular multiply SHALL be interleaved shift-add. Per operand bit, MSB first: r=2r+(a_bit?b:0), then N is subtracted conditionally up to twice, so r<N. The multiply SHALL take exactly WIDTH+1 cycles (1 load plus WIDTH iterations) and use a WIDTH+2-bit internal accumulator.
REQ-018 In DONE, out_valid SHALL be high with plain and err stable. These SHALL hold while out_ready is low. On out_valid&&out_ready the block SHALL return to IDLE, and in_ready SHALL rise on the following cycle.
REQ-019 exp_d=0 with valid operands SHALL give plain=1 and err=0. cipher=0 SHALL give plain=0 when d>0.
REQ-020 in_valid SHALL be ignored while the block is busy; inputs changing mid-operation SHALL NOT affect the result.

Reset
REQ-021 While rst_n is low:
- The state SHALL be IDLE.
- in_ready SHALL be 1; out_valid, err and plain SHALL be 0.
- All datapath registers SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation; no out_valid SHALL follow for the aborted operand set.

Configuration
REQ-023 Macro RSA_CONST_TIME_EN defined: MULT SHALL execute for every bit, with the result selected by exp_d[i]. Latency from accept to out_valid SHALL be 2+2*WIDTH*(WIDTH+1) cycles.
REQ-024 Macro RSA_CONST_TIME_EN undefined: MULT SHALL execute only when exp_d[i]=1. Latency SHALL be 2+(WIDTH+popcount(d))*(WIDTH+1) cycles.
REQ-025 The error path (REQ-015) SHALL take 2 cycles from accept to out_valid in both builds.

Structure
REQ-026 A shared package SHALL hold the state enumeration, the default WIDTH and the multiply-latency constant WIDTH+1.
REQ-027 The interleaved multiplier SHALL be a sub-module named mod_mult_serial, with start/done handshake and operands a, b, n.

Verification
REQ-028 With WIDTH=16, N=3233, d=2753, c=2790 -> plain=65, err=0, and latency exactly per REQ-023 or REQ-024 for the build under test.
REQ-029 With WIDTH=16, N=3233, d=0, c=2790 -> plain=1; with c=0, d=2753 -> plain=0.
REQ-030 mod_n=1, or cipher=3233 with N=3233 -> err=1 and plain=0, 2 cycles after accept.
REQ-031 Hold out_ready low for 10 cycles in DONE -> out_valid, plain and err stable, in_ready low; release -> return to IDLE.
REQ-032 Assert rst_n low mid-SQUARE -> outputs at reset values immediately; the next operand set returns the correct result and no stale out_valid appears.
REQ-033 Toggle cipher/exp_d/mod_n randomly while busy and drive in_valid high -> result unchanged and no second accept.

Source files
------------

// File: rtl/rsa_decrypt_core_pkg.sv
// ============================================================================
// Module      : rsa_decrypt_core_pkg
// Description : Shared state encoding and sizing constants for the RSA core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_decrypt_core_pkg;

   localparam int DEFAULT_WIDTH = 128;
   localparam int MULT_LATENCY  = DEFAULT_WIDTH + 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SQUARE = 3'd2,
      ST_MULT   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // One load cycle followed by one iteration per operand bit.
   function automatic int mult_latency(input int width);
      return width + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rsa_decrypt_core_mult.sv
// ============================================================================
// Module      : mod_mult_serial
// Description : Interleaved shift-add modular multiplier, r = a*b mod n.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_mult_serial
   import rsa_decrypt_core_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_n,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int AW = WIDTH + 2;

   logic             r_busy;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_n;
   logic [AW-1:0]    r_r;

   logic [AW-1:0]    w_n_ext;
   logic [AW-1:0]    w_sum;
   logic [AW-1:0]    w_s1;
   logic [AW-1:0]    w_s2;

   // r < n and b < n keep 2r+b below 3n, so two conditional subtracts suffice.
   always_comb begin
      w_n_ext = {2'b00, r_n};
      w_sum   = (r_r << 1) + (r_a[WIDTH-1] ? {2'b00, r_b} : {AW{1'b0}});
      w_s1    = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
      w_s2    = (w_s1 >= w_n_ext) ? (w_s1 - w_n_ext) : w_s1;
   end

   assign o_done   = r_busy && (r_cnt == '0);
   assign o_result = w_s2[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_n    <= '0;
         r_r    <= '0;
      end else if (!r_busy) begin
         if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(mult_latency(WIDTH) - 2);
            r_a    <= i_a;
            r_b    <= i_b;
            r_n    <= i_n;
            r_r    <= '0;
         end
      end else begin
         r_r <= w_s2;
         r_a <= r_a << 1;
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rsa_decrypt_core.sv
// ============================================================================
// Module      : rsa_decrypt_core
// Description : Left-to-right square-and-multiply RSA decryption, c^d mod N.
//               Build macro RSA_CONST_TIME_EN runs MULT for every exponent bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_decrypt_core
   import rsa_decrypt_core_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] cipher,
   input  logic [WIDTH-1:0] exp_d,
   input  logic [WIDTH-1:0] mod_n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] plain,
   output logic             err
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_c;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_plain;
   logic [IW-1:0]    r_idx;
   logic             r_err;

   logic             w_bad;
   logic             w_bit;
   logic             w_last;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_b;
   logic [WIDTH-1:0] w_mul_res;
   logic [WIDTH-1:0] w_mult_acc;

   assign w_bad      = (r_n < WIDTH'(2)) || (r_c >= r_n);
   assign w_bit      = r_d[r_idx];
   assign w_last     = (r_idx == '0);
   assign w_mult_acc = w_bit ? w_mul_res : r_acc;

   assign plain = r_plain;
   assign err   = r_err;

   mod_mult_serial #(
      .WIDTH    (WIDTH)
   ) u_mult (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_mul_start),
      .i_a      (r_acc),
      .i_b      (w_mul_b),
      .i_n      (r_n),
      .o_done   (w_mul_done),
      .o_result (w_mul_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (in_valid) w_next_state = ST_LOAD;
         ST_LOAD:   w_next_state = w_bad ? ST_DONE : ST_SQUARE;
         ST_SQUARE: begin
            if (w_mul_done) begin
`ifdef RSA_CONST_TIME_EN
               w_next_state = ST_MULT;
`else
               if (w_bit)       w_next_state = ST_MULT;
               else if (w_last) w_next_state = ST_DONE;
               else             w_next_state = ST_SQUARE;
`endif
            end
         end
         ST_MULT:   if (w_mul_done) w_next_state = w_last ? ST_DONE : ST_SQUARE;
         ST_DONE:   if (out_ready) w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (r_state == ST_IDLE);
      out_valid   = (r_state == ST_DONE);
      w_mul_start = (r_state == ST_SQUARE) || (r_state == ST_MULT);
      w_mul_b     = (r_state == ST_MULT) ? r_c : r_acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c     <= '0;
         r_d     <= '0;
         r_n     <= '0;
         r_acc   <= '0;
         r_plain <= '0;
         r_idx   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_c     <= cipher;
                  r_d     <= exp_d;
                  r_n     <= mod_n;
                  r_plain <= '0;
                  r_err   <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_bad) begin
                  r_err <= 1'b1;
               end else begin
                  r_acc <= WIDTH'(1);
                  r_idx <= IW'(WIDTH - 1);
               end
            end
            ST_SQUARE: begin
               if (w_mul_done) begin
                  r_acc <= w_mul_res;
`ifdef RSA_CONST_TIME_EN
`else
                  // MULT is skipped for a zero bit, so the bit is retired here.
                  if (!w_bit) begin
                     if (w_last) r_plain <= w_mul_res;
                     else        r_idx   <= r_idx - 1'b1;
                  end
`endif
               end
            end
            ST_MULT: begin
               if (w_mul_done) begin
                  r_acc <= w_mult_acc;
                  if (w_last) r_plain <= w_mult_acc;
                  else        r_idx   <= r_idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rsa_decrypt_core.sv
// ============================================================================
// Module      : tb_rsa_decrypt_core
// Description : Scoreboard bench for rsa_decrypt_core (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rsa_decrypt_core;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] cipher = '0;
   logic [W-1:0] exp_d = '0;
   logic [W-1:0] mod_n = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] plain;
   logic         err;

   rsa_decrypt_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cipher    (cipher),
      .exp_d     (exp_d),
      .mod_n     (mod_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .plain     (plain),
      .err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] plain;
      bit           err;
      int           acc_cyc;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_sent  = 0;
   int   n_acc   = 0;
   bit   bp_en   = 1'b0;
   bit   prev_ov = 1'b0;
   bit   want_ready = 1'b0;
   int   first_cyc = 0;

   // Right-to-left binary exponentiation on plain integers.
   function automatic longint unsigned ref_modexp(longint unsigned c, longint unsigned d,
                                                  longint unsigned n);
      longint unsigned r = 1;
      longint unsigned b = c % n;
      longint unsigned e = d;
      while (e != 0) begin
         if (e[0]) r = (r * b) % n;
         b = (b * b) % n;
         e = e >> 1;
      end
      return r % n;
   endfunction

   task automatic chk(input bit ok, input string name, input longint unsigned act,
                      input longint unsigned expv);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] n,
                         input bit noise, input int hold, input int abort_after);
      exp_t e;
      bit   ok;
      bit   seen;
      int   held;
      @(posedge clk); #1;
      cipher   = c;
      exp_d    = d;
      mod_n    = n;
      in_valid = 1'b1;
      out_ready = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk(1'b0, "accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      e.acc_cyc = cyc;
      if (n < 2 || c >= n) begin
         e.err   = 1'b1;
         e.plain = '0;
         e.lat   = 2;
      end else begin
         e.err   = 1'b0;
         e.plain = W'(ref_modexp(longint'(c), longint'(d), longint'(n)));
`ifdef RSA_CONST_TIME_EN
         e.lat   = 2 + 2 * W * (W + 1);
`else
         e.lat   = 2 + (W + $countones(d)) * (W + 1);
`endif
      end
      sb_q.push_back(e);
      n_sent++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (abort_after > 0) begin
         repeat (abort_after) @(posedge clk);
         #1;
         rst_n = 1'b0;
         sb_q.delete();
         repeat (3) @(posedge clk);
         #1;
         rst_n = 1'b1;
         return;
      end
      seen = 1'b0;
      held = 0;
      ok   = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         if (noise && !seen) begin
            cipher   = W'($urandom);
            exp_d    = W'($urandom);
            mod_n    = W'($urandom);
            in_valid = 1'b1;
         end
         if (hold > 0) out_ready = (held >= hold);
         else          out_ready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            held++;
            if (noise) in_valid = 1'b0;
         end
         @(posedge clk);
         if (sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         #1;
      end
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk(ok, "result_timeout", 64'(ok), 1);
   endtask

   initial begin
      fork
         begin : driver
            logic [W-1:0] rn;
            logic [W-1:0] rc;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            run_op(16'd2790, 16'd2753, 16'd3233, 1'b0, 0, 0);
            run_op(16'd2790, 16'd0,    16'd3233, 1'b0, 0, 0);
            run_op(16'd0,    16'd2753, 16'd3233, 1'b0, 0, 0);
            run_op(16'd5,    16'd7,    16'd1,    1'b0, 0, 0);
            run_op(16'd3233, 16'd2753, 16'd3233, 1'b0, 0, 0);
            run_op(16'd0,    16'd3,    16'd0,    1'b0, 0, 0);
            run_op(16'hFFFE, 16'hFFFF, 16'hFFFF, 1'b0, 0, 0);
            run_op(16'd1,    16'd2,    16'd2,    1'b0, 0, 0);
            run_op(16'd2790, 16'd2753, 16'd3233, 1'b0, 10, 0);
            run_op(16'd123,  16'd2753, 16'd3233, 1'b1, 0, 0);
            run_op(16'd2790, 16'd2753, 16'd3233, 1'b0, 0, 30);
            run_op(16'd2790, 16'd2753, 16'd3233, 1'b0, 0, 0);
            bp_en = 1'b1;
            for (int k = 0; k < 24; k++) begin
               rn = W'($urandom_range(65535, 2));
               if ($urandom_range(7, 0) == 0) rc = W'($urandom_range(65535, 32'(rn)));
               else                           rc = W'($urandom % 32'(rn));
               run_op(rc, W'($urandom), rn, 1'(k % 5 == 0), 0, 0);
            end
            repeat (5) @(posedge clk);
         end
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk);
               if (!rst_n) begin
                  chk(in_ready == 1'b1 && out_valid == 1'b0 && err == 1'b0 && plain == '0,
                      "reset_outputs", {in_ready, out_valid, err, plain}, {1'b1, 18'd0});
                  prev_ov    = 1'b0;
                  want_ready = 1'b0;
               end else begin
                  if (want_ready) begin
                     chk(in_ready == 1'b1, "ready_after_done", 64'(in_ready), 1);
                     want_ready = 1'b0;
                  end
                  if (in_valid && in_ready) n_acc++;
                  if (out_valid) begin
                     if (!prev_ov) first_cyc = cyc;
                     chk(in_ready == 1'b0, "ready_low_in_done", 64'(in_ready), 0);
                     if (sb_q.size() == 0) begin
                        chk(1'b0, "unexpected_out_valid", 1, 0);
                     end else begin
                        chk(plain == sb_q[0].plain, "plain", 64'(plain), 64'(sb_q[0].plain));
                        chk(err == sb_q[0].err, "err", 64'(err), 64'(sb_q[0].err));
                        if (out_ready) begin
                           e = sb_q.pop_front();
                           chk(first_cyc - e.acc_cyc == e.lat, "latency",
                               64'(first_cyc - e.acc_cyc), 64'(e.lat));
                           want_ready = 1'b1;
                        end
                     end
                     prev_ov = !out_ready;
                  end else begin
                     prev_ov = 1'b0;
                  end
               end
            end
         end
      join_any
      disable fork;
      chk(n_acc == n_sent, "accept_count", 64'(n_acc), 64'(n_sent));
      chk(sb_q.size() == 0, "pending_results", 64'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
